// File: rtl/activation_writeback.sv
// activation_writeback: streams accumulator rows through ReLU / rounding shift / saturation
// into the unified buffer, one row per cycle, with a two-cycle read-to-write pipeline.
module activation_writeback #(
  parameter int LANES = 32,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [6:0]               acc_base_i,
  input  logic [11:0]              ub_base_i,
  input  logic [6:0]               num_rows_i,
  input  logic                     relu_en_i,
  input  logic [4:0]               shift_i,
  input  logic                     stall_i,
  input  logic [LANES*ACC_W-1:0]   acc_data_i,
  output logic                     acc_rd_en_o,
  output logic [6:0]               acc_addr_rd_o,
  output logic                     ub_write_o,
  output logic [11:0]              ub_addr_wr_o,
  output logic [LANES*OUT_W-1:0]   ub_data_o,
  output logic                     busy_o,
  output logic                     done_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  state_t                   r_state, w_next;
  logic [6:0]               r_acc_base;
  logic [11:0]              r_ub_base;
  logic [7:0]               r_rows, r_iss_cnt, r_wr_cnt;
  logic                     r_relu, r_rd_v, r_wr_v;
  logic [4:0]               r_shift;
  logic [LANES*OUT_W-1:0]   r_data, w_q;
  logic                     w_start, w_rd, w_last_iss, w_last_wr;
  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_rd       = (r_state == S_ISSUE) && !stall_i;
  assign w_last_iss = r_iss_cnt == r_rows - 8'd1;
  assign w_last_wr  = r_wr_v && (r_wr_cnt == r_rows - 8'd1);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE)  ? (start_i ? S_ISSUE : S_IDLE) :
             (r_state == S_ISSUE) ? ((w_rd && w_last_iss) ? S_DRAIN : S_ISSUE) :
             (r_state == S_DRAIN) ? (w_last_wr ? S_DONE : S_DRAIN) : S_IDLE;
  end
  // Reset clears the read/write valid pipeline so aborted rows never land in the buffer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_acc_base <= '0;
      r_ub_base  <= '0;
      r_rows     <= '0;
      r_relu     <= 1'b0;
      r_shift    <= '0;
      r_iss_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_rd_v     <= 1'b0;
      r_wr_v     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_acc_base <= acc_base_i;
        r_ub_base  <= ub_base_i;
        r_rows     <= {num_rows_i == 7'd0, num_rows_i};
        r_relu     <= relu_en_i;
        r_shift    <= shift_i;
        r_iss_cnt  <= '0;
        r_wr_cnt   <= '0;
      end else begin
        if (w_rd) r_iss_cnt <= r_iss_cnt + 8'd1;
        if (r_wr_v) r_wr_cnt <= r_wr_cnt + 8'd1;
      end
      r_rd_v <= w_rd;
      r_wr_v <= r_rd_v;
      if (r_rd_v) r_data <= w_q;
    end
  end
  // One extra bit of headroom keeps x + 2^(shift-1) exact before the arithmetic shift
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACC_W:0] w_x, w_rnd, w_s, w_y;
    logic                  w_neg;
    assign w_neg = acc_data_i[g*ACC_W + ACC_W-1];
    assign w_x   = (r_relu && w_neg) ? '0 : {w_neg, acc_data_i[g*ACC_W +: ACC_W]};
    assign w_rnd = (r_shift == 5'd0) ? '0 : (ACC_W+1)'(1) << (r_shift - 5'd1);
    assign w_s   = w_x + w_rnd;
    assign w_y   = w_s >>> r_shift;
    assign w_q[g*OUT_W +: OUT_W] = (w_y > MAXV) ? MAXV[OUT_W-1:0] :
                                   (w_y < MINV) ? MINV[OUT_W-1:0] : w_y[OUT_W-1:0];
  end
  assign acc_rd_en_o   = w_rd;
  assign acc_addr_rd_o = r_acc_base + r_iss_cnt[6:0];
  assign ub_write_o    = r_wr_v;
  assign ub_addr_wr_o  = r_ub_base + {4'd0, r_wr_cnt};
  assign ub_data_o     = r_data;
  assign busy_o        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done_o        = r_state == S_DONE;
endmodule

// File: tb/tb_activation_writeback.sv
// tb_activation_writeback: directed jobs against a row-level model of the writeback
// (expected read/write queues, requantisation in plain integer arithmetic).
module tb_activation_writeback;
  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;

  logic clk_i, rst_i, start_i, relu_en_i, stall_i;
  logic [6:0] acc_base_i, num_rows_i;
  logic [11:0] ub_base_i;
  logic [4:0] shift_i;
  logic [LANES*ACC_W-1:0] acc_data_i;
  logic acc_rd_en_o, ub_write_o, busy_o, done_o;
  logic [6:0] acc_addr_rd_o;
  logic [11:0] ub_addr_wr_o;
  logic [LANES*OUT_W-1:0] ub_data_o;

  activation_writeback #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .acc_base_i(acc_base_i),
    .ub_base_i(ub_base_i), .num_rows_i(num_rows_i), .relu_en_i(relu_en_i),
    .shift_i(shift_i), .stall_i(stall_i), .acc_data_i(acc_data_i),
    .acc_rd_en_o(acc_rd_en_o), .acc_addr_rd_o(acc_addr_rd_o), .ub_write_o(ub_write_o),
    .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o), .busy_o(busy_o), .done_o(done_o));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [ACC_W-1:0] acc_mem [128][LANES];
  int n_chk = 0, n_pass = 0;

  // model state
  int exp_rd[$], exp_wa[$];
  logic [LANES*OUT_W-1:0] exp_wd[$];
  bit m_busy, pend_done, rd_h1, rd_h2, done_flag;
  logic [LANES*OUT_W-1:0] last_data;
  int cyc, start_cyc, done_rel;
  int rd_rel[$], rd_adr[$], wr_rel[$], wr_adr[$];
  logic [LANES*OUT_W-1:0] wr_dat[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic bad(input string nm, input longint act);
    n_chk++;
    $display("FAIL %s: got %0d with nothing expected", nm, act);
  endtask

  function automatic longint requant(input longint x_in, input bit relu, input int sh);
    longint x, y, d, hi, lo;
    x = x_in;
    if (relu && x < 0) x = 0;
    if (sh == 0) y = x;
    else begin
      d = longint'(1) << sh;
      y = x + d / 2;
      y = (y >= 0) ? y / d : -((-y + d - 1) / d);
    end
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -hi - 1;
    return (y > hi) ? hi : (y < lo) ? lo : y;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] model_row(input int row, input bit relu, input int sh);
    logic [LANES*OUT_W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*OUT_W +: OUT_W] = OUT_W'(requant(longint'($signed(acc_mem[row][l])), relu, sh));
    return r;
  endfunction

  function automatic longint lane(input logic [LANES*OUT_W-1:0] d, input int l);
    return longint'($signed(d[l*OUT_W +: OUT_W]));
  endfunction

  task automatic compare();
    bit cur_busy, cur_done;
    int n;
    cyc++;
    if (!rst_i) begin
      chk("rst_outputs_zero", longint'(|{acc_rd_en_o, acc_addr_rd_o, ub_write_o, ub_addr_wr_o,
                                          ub_data_o, busy_o, done_o}), 0);
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      m_busy = 0; pend_done = 0; rd_h1 = 0; rd_h2 = 0; last_data = '0;
    end else begin
      cur_busy = m_busy;
      cur_done = pend_done;
      pend_done = 0;
      chk("done", done_o, cur_done);
      chk("busy", busy_o, cur_busy);
      if (done_o) begin done_flag = 1; done_rel = cyc - start_cyc; end
      chk("wr_latency", ub_write_o, rd_h2);
      rd_h2 = rd_h1;
      rd_h1 = acc_rd_en_o;
      if (acc_rd_en_o) begin
        rd_rel.push_back(cyc - start_cyc);
        rd_adr.push_back(acc_addr_rd_o);
        if (exp_rd.size() == 0) bad("rd_unexpected", acc_addr_rd_o);
        else chk("rd_addr", acc_addr_rd_o, exp_rd.pop_front());
      end
      if (ub_write_o) begin
        wr_rel.push_back(cyc - start_cyc);
        wr_adr.push_back(ub_addr_wr_o);
        wr_dat.push_back(ub_data_o);
        last_data = ub_data_o;
        if (exp_wa.size() == 0) bad("wr_unexpected", ub_addr_wr_o);
        else begin
          chk("wr_addr", ub_addr_wr_o, exp_wa.pop_front());
          chk("wr_data", ub_data_o, exp_wd.pop_front());
          if (exp_wa.size() == 0) begin pend_done = 1; m_busy = 0; end
        end
      end else chk("wr_hold", ub_data_o, last_data);
      if (start_i && !cur_busy && !cur_done) begin
        start_cyc = cyc;
        n = (num_rows_i == 0) ? 128 : int'(num_rows_i);
        for (int i = 0; i < n; i++) begin
          exp_rd.push_back((int'(acc_base_i) + i) % 128);
          exp_wa.push_back((int'(ub_base_i) + i) % 4096);
          exp_wd.push_back(model_row((int'(acc_base_i) + i) % 128, relu_en_i, shift_i));
        end
        m_busy = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    compare();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int a, input int u, input int n, input bit relu, input int sh);
    rd_rel.delete(); rd_adr.delete(); wr_rel.delete(); wr_adr.delete(); wr_dat.delete();
    done_flag = 0;
    start_i = 1; acc_base_i = 7'(a); ub_base_i = 12'(u); num_rows_i = 7'(n);
    relu_en_i = relu; shift_i = 5'(sh);
    tick();
    start_i = 0;
  endtask

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim && !done_flag; k++) tick();
    chk("done_seen", done_flag, 1);
  endtask

  // accumulator memory: data valid the cycle after a read strobe, garbage otherwise
  initial begin
    logic rd;
    logic [6:0] a;
    acc_data_i = '0;
    forever begin
      @(negedge clk_i);
      rd = acc_rd_en_o;
      a = acc_addr_rd_o;
      @(posedge clk_i);
      #1;
      for (int l = 0; l < LANES; l++)
        acc_data_i[l*ACC_W +: ACC_W] = rd ? acc_mem[a][l] : ACC_W'($urandom());
    end
  end

  initial begin
    int nb;
    rst_i = 1; start_i = 0; relu_en_i = 0; stall_i = 0;
    acc_base_i = 0; num_rows_i = 0; ub_base_i = 0; shift_i = 0;
    cyc = 0; start_cyc = 0; done_rel = 0; last_data = '0;
    for (int r = 0; r < 128; r++)
      for (int l = 0; l < LANES; l++) acc_mem[r][l] = ACC_W'($urandom());
    #2 rst_i = 0;
    #1;
    chk("reset_rd_en", acc_rd_en_o, 0);
    chk("reset_ub_write", ub_write_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_ub_data", ub_data_o, 0);
    chk("reset_ub_addr", ub_addr_wr_o, 0);
    repeat (3) tick();
    rst_i = 1;
    repeat (2) tick();

    chk("model_relu_on", requant(74565, 1, 4), 4660);
    chk("model_neg_small", requant(-5, 0, 4), 0);
    chk("model_neg_round", requant(-70000, 0, 4), -4375);
    chk("model_sat_hi", requant(40000, 0, 0), 32767);
    chk("model_sat_lo", requant(-70000, 1, 4), 0);

    // basic timing and saturation at shift 0
    acc_mem[5][0] = 32'd1234;
    acc_mem[6][1] = 32'd40000;
    acc_mem[7][2] = -32'sd40000;
    start_job(5, 100, 3, 0, 0);
    wait_done(20);
    chk("basic_rd_count", rd_rel.size(), 3);
    chk("basic_rd_first_cyc", rd_rel[0], 1);
    chk("basic_rd_last_cyc", rd_rel[2], 3);
    chk("basic_rd_addr0", rd_adr[0], 5);
    chk("basic_rd_addr2", rd_adr[2], 7);
    chk("basic_wr_first_cyc", wr_rel[0], 3);
    chk("basic_wr_last_cyc", wr_rel[2], 5);
    chk("basic_wr_addr0", wr_adr[0], 100);
    chk("basic_wr_addr2", wr_adr[2], 102);
    chk("basic_done_cyc", done_rel, 6);
    chk("basic_lane_pass", lane(wr_dat[0], 0), 1234);
    chk("basic_sat_pos", lane(wr_dat[1], 1), 32767);
    chk("basic_sat_neg", lane(wr_dat[2], 2), -32768);

    // rounding with and without ReLU
    acc_mem[10][0] = 32'h0001_2345;
    acc_mem[10][1] = -32'sd5;
    acc_mem[10][2] = 32'd70000;
    acc_mem[10][3] = -32'sd70000;
    start_job(10, 200, 1, 1, 4);
    wait_done(20);
    chk("relu_lane0", lane(wr_dat[0], 0), 4660);
    chk("relu_lane1", lane(wr_dat[0], 1), 0);
    chk("relu_lane2", lane(wr_dat[0], 2), 4375);
    chk("relu_lane3", lane(wr_dat[0], 3), 0);
    start_job(10, 201, 1, 0, 4);
    wait_done(20);
    chk("norelu_lane0", lane(wr_dat[0], 0), 4660);
    chk("norelu_lane1", lane(wr_dat[0], 1), 0);
    chk("norelu_lane2", lane(wr_dat[0], 2), 4375);
    chk("norelu_lane3", lane(wr_dat[0], 3), -4375);

    // address wrap on both sides
    start_job(126, 4095, 4, 0, 2);
    wait_done(20);
    chk("wrap_rd0", rd_adr[0], 126);
    chk("wrap_rd1", rd_adr[1], 127);
    chk("wrap_rd2", rd_adr[2], 0);
    chk("wrap_rd3", rd_adr[3], 1);
    chk("wrap_wr0", wr_adr[0], 4095);
    chk("wrap_wr1", wr_adr[1], 0);
    chk("wrap_wr3", wr_adr[3], 2);

    // rows=0 means a full 128-row job
    start_job(3, 50, 0, 1, 1);
    wait_done(300);
    chk("full_rd_count", rd_adr.size(), 128);
    chk("full_wr_count", wr_adr.size(), 128);

    // stall for three cycles after the second read
    start_job(40, 300, 4, 0, 3);
    tick();
    tick();
    stall_i = 1;
    repeat (3) tick();
    stall_i = 0;
    wait_done(30);
    chk("stall_rd_count", rd_rel.size(), 4);
    chk("stall_rd2_cyc", rd_rel[2], 6);
    chk("stall_rd3_cyc", rd_rel[3], 7);
    chk("stall_wr_count", wr_adr.size(), 4);
    chk("stall_done_cyc", done_rel, 10);

    // start pulses while busy and in the done cycle are ignored
    start_job(60, 400, 3, 1, 0);
    tick();
    start_i = 1; acc_base_i = 0; ub_base_i = 12'd9; num_rows_i = 7'd9; relu_en_i = 0; shift_i = 5'd7;
    tick();
    start_i = 0;
    repeat (3) tick();
    start_i = 1;
    tick();
    start_i = 0;
    repeat (5) tick();
    chk("busy_start_wr_count", wr_adr.size(), 3);
    chk("busy_start_rd_count", rd_adr.size(), 3);
    chk("busy_start_done", done_flag, 1);

    // saturation-heavy random rows, including the largest shift
    start_job(70, 1000, 8, 0, 0);
    wait_done(30);
    start_job(80, 2000, 5, 0, 31);
    wait_done(30);

    // asynchronous reset in the middle of the drain
    start_job(90, 500, 3, 0, 2);
    repeat (3) tick();
    rst_i = 0;
    #1;
    chk("midrst_ub_write", ub_write_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rd_en", acc_rd_en_o, 0);
    chk("midrst_ub_data", ub_data_o, 0);
    chk("midrst_ub_addr", ub_addr_wr_o, 0);
    chk("midrst_acc_addr", acc_addr_rd_o, 0);
    chk("midrst_writes_before", wr_adr.size(), 1);
    repeat (2) tick();
    rst_i = 1;
    nb = wr_adr.size();
    repeat (8) tick();
    chk("midrst_no_late_write", wr_adr.size(), nb);
    chk("midrst_no_done", done_flag, 0);

    start_job(1, 7, 2, 0, 0);
    wait_done(20);
    chk("recover_wr_count", wr_adr.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
